mem_arbiter_adapter: RTL and testbench
======================================

// Module: mem_arbiter_adapter
// PURPOSE
//  Parametrised byte-serial memory adapter. It arbitrates N_PORTS requesters (e.g. insfetch, load/store)
//  onto the single 8-bit RAM/IO bus of the cpu top. Each access is 1/2/4 bytes, little-endian.
//  Adds round-robin arbitration, per-port flush abort, IO write throttling and rdy_in freeze.
// PARAMETERS
//  N_PORTS     2      number of requester channels (1..4)
//  FLUSH_MASK  2'b11  N_PORTS bits; bit i=1 -> reads of port i are aborted by flush_pipline
//  IO_GAP      1      idle cycles forced between consecutive IO-range write bytes
// PORTS
//  clk_in          in   1          system clock
//  rst_in          in   1          synchronous reset, active-low (rst_in==0 resets at posedge)
//  rdy_in          in   1          0 = freeze all state; mem_wr masked to 0
//  flush_pipline   in   1          abort flushable reads, drop flushable requests
//  mem_din         in   8          read byte, valid one cycle after its address
//  mem_dout        out  8          write byte
//  mem_a           out  32         byte address
//  mem_wr          out  1          1 = write this cycle
//  io_buffer_full  in   1          uart buffer full
//  req_in          in   N_PORTS    per-port request, held until accepted
//  rw_in           in   N_PORTS    1 = write
//  size_in         in   2*N_PORTS  00 byte, 01 half, 10 word (11 treated as word)
//  sext_in         in   N_PORTS    1 = sign-extend read data
//  addr_in         in   32*N_PORTS access base address
//  wdata_in        in   32*N_PORTS write data, low bytes used
//  accepted_out    out  N_PORTS    one-cycle pulse: request latched, inputs may change
//  done_out        out  N_PORTS    one-cycle pulse: access complete
//  rdata_out       out  32         read result, valid while any done_out bit is high
// BEHAVIOUR
//  Reset: state IDLE, mem_a=0, mem_dout=0, mem_wr=0, accepted_out=0, done_out=0, rdata_out=0,
//   rr pointer=N_PORTS-1 (port 0 highest priority first).
//  rdy_in=0: no register updates; mem_wr output = mem_wr_q & rdy_in. No duplicate write occurs.
//  States: IDLE, READ, WRITE, IOWAIT.
//  IDLE: at the edge where any req_in is high, grant the first requesting port after the rr pointer
//   (wrapping). Latch addr/rw/size/sext/wdata. Pulse accepted_out[g]. Set rr pointer=g.
//   Drive mem_a=addr byte 0 and go to READ/WRITE. A flushable port's request is ignored at an edge
//   where flush_pipline=1.
//  READ, n bytes: mem_a = base+k in cycles 1..n after the grant edge. Byte k is captured from mem_din
//   in cycle k+2. rdata is assembled LE and zero- or sign-extended from bit 8n-1. done_out pulses and
//   rdata_out is valid in cycle n+2, with return to IDLE at the same edge. Word read: 6-cycle latency.
//  WRITE: mem_wr=1, mem_dout=wdata byte k, mem_a=base+k in cycles 1..n. done_out pulses in cycle n+1.
//  IO range (addr[17:16]==2'b11) write byte: launch is blocked while io_buffer_full=1 (go to IOWAIT,
//   mem_wr=0). IOWAIT resumes with the same byte the edge after io_buffer_full samples 0. After an IO
//   byte, IO_GAP idle cycles are inserted before the next IO byte.
//  flush_pipline=1 in READ/IDLE with a flushable port owning the bus: abort to IDLE with mem_wr=0.
//   No done pulse; partial rdata is discarded. WRITE and IOWAIT always run to completion and signal
//   done (no torn stores).
//  Simultaneous done and new request: the new grant is taken at the following edge (1 idle cycle minimum).
//  Address arithmetic is 32-bit wrapping; no alignment check. Only one transaction is in flight.
// TESTING
//  Word read port0 addr 0x100, RAM 0x100..103 = 11 22 33 84 -> accepted cycle 1,
//   done_out=01 cycle 6, rdata_out=0x84332211.
//  Byte read sext=1 of 0x80 -> rdata_out=0xFFFFFF80; sext=0 -> 0x00000080.
//  Both ports request every cycle -> grants alternate 0,1,0,1; neither port waits more than one transaction.
//  Half write 0x30000 data 0xBEEF, io_buffer_full high 3 cycles -> mem_wr low 3 cycles, then 0xEF,
//   IO_GAP idle, then 0xBE; single done pulse.
//  flush_pipline at cycle 3 of port0 word read -> no done_out, mem_wr 0, IDLE at cycle 4;
//   the same flush during a word write -> all 4 bytes written, done pulses.
//  rdy_in low 2 cycles mid-write, then rst_in=0 mid-read -> no repeated byte; all outputs at reset values next cycle.

Source files
------------

// File: rtl/mem_arbiter_adapter.sv
// Byte-serial memory adapter: round-robin arbitration of N_PORTS requesters onto one 8-bit RAM/IO bus,
// with flush abort of reads, IO write throttling and a global rdy_in freeze.
module mem_arbiter_adapter #(
  parameter int                 N_PORTS    = 2,
  parameter logic [N_PORTS-1:0] FLUSH_MASK = {N_PORTS{1'b1}},
  parameter int                 IO_GAP     = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_pipline,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [31:0]           mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic [N_PORTS-1:0]    req_in,
  input  logic [N_PORTS-1:0]    rw_in,
  input  logic [2*N_PORTS-1:0]  size_in,
  input  logic [N_PORTS-1:0]    sext_in,
  input  logic [32*N_PORTS-1:0] addr_in,
  input  logic [32*N_PORTS-1:0] wdata_in,
  output logic [N_PORTS-1:0]    accepted_out,
  output logic [N_PORTS-1:0]    done_out,
  output logic [31:0]           rdata_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, IOWAIT = 2'd3} state_t;

  function automatic logic [N_PORTS-1:0] onehot(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0001 << idx;
    return v[N_PORTS-1:0];
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    logic [1:0] r;
    case (sz)
      2'b00:   r = 2'd0;
      2'b01:   r = 2'd1;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] last, input logic sx);
    logic [31:0] r;
    case (last)
      2'd0:    r = {{24{sx & d[7]}}, d[7:0]};
      2'd1:    r = {{16{sx & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  state_t      state_r;
  logic [1:0]  rr_r, own_r, last_r, idx_r;
  logic [2:0]  cnt_r;
  logic [31:0] base_r, wdata_r, data_r;
  logic        sext_r, mem_wr_r;
  logic [7:0]  cool_r;

  logic [N_PORTS-1:0] eligible_s;
  logic [3:0]   elig4_s, rw4_s, sext4_s, flush4_s;
  logic [7:0]   size8_s;
  logic [127:0] addr128_s, wdata128_s;
  logic         grant_valid_s, g_rw_s, g_sext_s, own_flush_s;
  logic [1:0]   grant_idx_s, g_size_s;
  logic [31:0]  g_addr_s, g_wdata_s;
  logic         io_on_bus_s, io_ok_s, launch_block_s;
  logic [1:0]   launch_idx_s;
  logic [31:0]  launch_base_s, launch_word_s, launch_addr_s;
  logic [7:0]   launch_byte_s;
  logic [1:0]   rd_byte_s;
  logic         rd_cap_s, rd_last_s, rd_issue_s;
  logic [31:0]  rd_addr_s, data_next_s;

  assign mem_wr = mem_wr_r & rdy_in;

  // Round-robin pick: first eligible port strictly after the last grant, wrapping.
  always_comb begin
    eligible_s    = req_in & ~(flush_pipline ? FLUSH_MASK : {N_PORTS{1'b0}});
    elig4_s       = 4'(eligible_s);
    grant_valid_s = 1'b0;
    grant_idx_s   = 2'd0;
    for (int i = 1; i <= N_PORTS; i++) begin
      if (!grant_valid_s && elig4_s[2'((int'(rr_r) + i) % N_PORTS)]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = 2'((int'(rr_r) + i) % N_PORTS);
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // Request fields of the granted port and flushability of the current owner.
  always_comb begin
    rw4_s       = 4'(rw_in);
    sext4_s     = 4'(sext_in);
    flush4_s    = 4'(FLUSH_MASK);
    size8_s     = 8'(size_in);
    addr128_s   = 128'(addr_in);
    wdata128_s  = 128'(wdata_in);
    g_rw_s      = rw4_s[grant_idx_s];
    g_sext_s    = sext4_s[grant_idx_s];
    g_size_s    = size8_s[{grant_idx_s, 1'b0} +: 2];
    g_addr_s    = addr128_s[{grant_idx_s, 5'b00000} +: 32];
    g_wdata_s   = wdata128_s[{grant_idx_s, 5'b00000} +: 32];
    own_flush_s = flush4_s[own_r];
  end

  // Next write byte to launch and whether the IO throttle holds it back.
  always_comb begin
    io_on_bus_s   = mem_wr_r && (mem_a[17:16] == 2'b11);
    io_ok_s       = (IO_GAP == 0) || (!io_on_bus_s && (cool_r <= 8'd1));
    launch_idx_s  = 2'd0;
    launch_base_s = g_addr_s;
    launch_word_s = g_wdata_s;
    if (state_r == WRITE) begin
      launch_idx_s  = idx_r + 2'd1;
      launch_base_s = base_r;
      launch_word_s = wdata_r;
    end else if (state_r == IOWAIT) begin
      launch_idx_s  = idx_r;
      launch_base_s = base_r;
      launch_word_s = wdata_r;
    end else begin
      launch_idx_s  = 2'd0;
    end
    launch_addr_s  = launch_base_s + {30'd0, launch_idx_s};
    launch_byte_s  = launch_word_s[{launch_idx_s, 3'b000} +: 8];
    launch_block_s = (launch_addr_s[17:16] == 2'b11) && (io_buffer_full || !io_ok_s);
  end

  // Read pipeline: cnt_r is the cycle number since the grant; data lags its address by one cycle.
  always_comb begin
    rd_issue_s  = (cnt_r <= {1'b0, last_r});
    rd_addr_s   = base_r + {29'd0, cnt_r};
    rd_cap_s    = (cnt_r >= 3'd2);
    rd_byte_s   = 2'(cnt_r - 3'd2);
    rd_last_s   = rd_cap_s && (rd_byte_s == last_r);
    data_next_s = data_r;
    data_next_s[{rd_byte_s, 3'b000} +: 8] = mem_din;
  end

  // Main sequencer; rdy_in low freezes every register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r      <= IDLE;
      rr_r         <= 2'(N_PORTS - 1);
      own_r        <= 2'd0;
      last_r       <= 2'd0;
      idx_r        <= 2'd0;
      cnt_r        <= 3'd0;
      base_r       <= 32'd0;
      wdata_r      <= 32'd0;
      data_r       <= 32'd0;
      sext_r       <= 1'b0;
      mem_wr_r     <= 1'b0;
      cool_r       <= 8'd0;
      mem_a        <= 32'd0;
      mem_dout     <= 8'd0;
      accepted_out <= {N_PORTS{1'b0}};
      done_out     <= {N_PORTS{1'b0}};
      rdata_out    <= 32'd0;
    end else if (rdy_in) begin
      accepted_out <= {N_PORTS{1'b0}};
      done_out     <= {N_PORTS{1'b0}};
      if (io_on_bus_s) begin
        cool_r <= 8'(IO_GAP);
      end else if (cool_r != 8'd0) begin
        cool_r <= cool_r - 8'd1;
      end else begin
        cool_r <= cool_r;
      end
      case (state_r)
        IDLE: begin
          mem_wr_r <= 1'b0;
          if (grant_valid_s) begin
            accepted_out <= onehot(grant_idx_s);
            rr_r         <= grant_idx_s;
            own_r        <= grant_idx_s;
            base_r       <= g_addr_s;
            wdata_r      <= g_wdata_s;
            last_r       <= last_idx(g_size_s);
            sext_r       <= g_sext_s;
            data_r       <= 32'd0;
            idx_r        <= 2'd0;
            mem_a        <= g_addr_s;
            if (!g_rw_s) begin
              state_r <= READ;
              cnt_r   <= 3'd1;
            end else if (launch_block_s) begin
              state_r <= IOWAIT;
            end else begin
              state_r  <= WRITE;
              mem_wr_r <= 1'b1;
              mem_dout <= launch_byte_s;
            end
          end
        end
        READ: begin
          if (flush_pipline && own_flush_s) begin
            state_r  <= IDLE;
            mem_wr_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 3'd1;
            if (rd_issue_s) begin
              mem_a <= rd_addr_s;
            end
            if (rd_cap_s) begin
              data_r <= data_next_s;
            end
            if (rd_last_s) begin
              rdata_out <= extend(data_next_s, last_r, sext_r);
              done_out  <= onehot(own_r);
              state_r   <= IDLE;
            end
          end
        end
        WRITE: begin
          if (idx_r == last_r) begin
            mem_wr_r <= 1'b0;
            done_out <= onehot(own_r);
            state_r  <= IDLE;
          end else if (launch_block_s) begin
            mem_wr_r <= 1'b0;
            idx_r    <= launch_idx_s;
            state_r  <= IOWAIT;
          end else begin
            mem_wr_r <= 1'b1;
            idx_r    <= launch_idx_s;
            mem_a    <= launch_addr_s;
            mem_dout <= launch_byte_s;
          end
        end
        IOWAIT: begin
          if (!launch_block_s) begin
            mem_wr_r <= 1'b1;
            mem_a    <= launch_addr_s;
            mem_dout <= launch_byte_s;
            state_r  <= WRITE;
          end else begin
            mem_wr_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          mem_wr_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_adapter.sv
// Scoreboard bench for mem_arbiter_adapter: a byte RAM model answers reads, a monitor checks every
// bus write and every done pulse against queues filled when requests are issued.
module tb_mem_arbiter_adapter;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, flush_pipline, io_buffer_full, mem_wr;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a, rdata_out;
  logic [1:0]  req_in, rw_in, sext_in, accepted_out, done_out;
  logic [3:0]  size_in;
  logic [63:0] addr_in, wdata_in;

  typedef struct packed {
    logic [1:0]  port;
    logic        is_read;
    logic [31:0] data;
  } done_t;

  done_t       exp_done_q[$];
  logic [39:0] exp_wr_q[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [7:0]  ram [0:65535];

  mem_arbiter_adapter #(.N_PORTS(2), .FLUSH_MASK(2'b11), .IO_GAP(1)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .req_in(req_in), .rw_in(rw_in), .size_in(size_in),
    .sext_in(sext_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .accepted_out(accepted_out), .done_out(done_out), .rdata_out(rdata_out)
  );

  always #5 clk = ~clk;

  // RAM model: registered read data, writes land at the edge.
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22; ram[16'h0102] = 8'h33;
    ram[16'h0103] = 8'h84; ram[16'h0104] = 8'h5A; ram[16'h0200] = 8'h80;
    mem_din = 8'h00;
    forever begin
      @(posedge clk);
      mem_din <= ram[mem_a[15:0]];
      if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  function automatic logic [1:0] oh(input int p);
    return (p == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic set_port(input int p, input logic rw, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd);
    rw_in[p] = rw;
    size_in[2*p +: 2] = sz;
    sext_in[p] = sx;
    addr_in[32*p +: 32] = a;
    wdata_in[32*p +: 32] = wd;
  endtask

  task automatic monitor();
    done_t       e;
    logic [39:0] w;
    forever begin
      @(negedge clk);
      if (rst_in && rdy_in) begin
        if (done_out != 2'b00) begin
          compared++;
          if (exp_done_q.size() == 0) begin
            mismatched++;
            $display("FAIL done_unexpected: got done_out=%b, required no done", done_out);
          end else begin
            e = exp_done_q.pop_front();
            if (done_out !== e.port || (e.is_read && rdata_out !== e.data)) begin
              mismatched++;
              $display("FAIL done_data: got done=%b rdata=%h, required done=%b rdata=%h",
                       done_out, rdata_out, e.port, e.data);
            end
          end
        end
        if (mem_wr) begin
          compared++;
          if (exp_wr_q.size() == 0) begin
            mismatched++;
            $display("FAIL write_unexpected: got a=%h d=%h, required no write", mem_a, mem_dout);
          end else begin
            w = exp_wr_q.pop_front();
            if ({mem_a, mem_dout} !== w) begin
              mismatched++;
              $display("FAIL write_byte: got a=%h d=%h, required a=%h d=%h",
                       mem_a, mem_dout, w[39:8], w[7:0]);
            end
          end
        end
      end
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (done_out != 2'b00) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL %s: got no done within 40 cycles, required a done pulse", name);
    end
    tick();
  endtask

  task automatic issue_read(input int p, input logic [31:0] a, input logic [1:0] sz,
                            input logic sx, input logic [31:0] exp);
    set_port(p, 1'b0, sz, sx, a, 32'd0);
    req_in = oh(p);
    tick();
    check("read_accept", {30'd0, accepted_out}, {30'd0, oh(p)});
    req_in = 2'b00;
    exp_done_q.push_back({oh(p), 1'b1, exp});
    wait_done("read_done");
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] exp;
  } rvec_t;

  initial begin
    rvec_t       rv [5];
    logic [1:0]  exp_port, got;
    rst_in = 1'b0; rdy_in = 1'b1; flush_pipline = 1'b0; io_buffer_full = 1'b0;
    req_in = 2'b00; rw_in = 2'b00; sext_in = 2'b00; size_in = 4'd0;
    addr_in = 64'd0; wdata_in = 64'd0;
    fork monitor(); join_none

    // Reset values
    tick(); tick();
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_dout_wr", {23'd0, mem_wr, mem_dout}, 32'd0);
    check("rst_pulses", {28'd0, accepted_out, done_out}, 32'd0);
    check("rst_rdata", rdata_out, 32'd0);
    rst_in = 1'b1;
    tick();

    // Word read with exact latency
    set_port(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    req_in = 2'b01;
    tick();
    check("accept_cycle1", {30'd0, accepted_out}, 32'd1);
    req_in = 2'b00;
    exp_done_q.push_back({2'b01, 1'b1, 32'h84332211});
    for (int c = 2; c <= 5; c++) begin
      tick();
      check("no_early_done", {30'd0, done_out}, 32'd0);
    end
    tick();
    check("done_cycle6", {30'd0, done_out}, 32'd1);
    tick();

    // Size / extension vectors
    rv[0] = {32'h200, 2'b00, 1'b1, 32'hFFFFFF80};
    rv[1] = {32'h200, 2'b00, 1'b0, 32'h00000080};
    rv[2] = {32'h102, 2'b01, 1'b1, 32'hFFFF8433};
    rv[3] = {32'h100, 2'b01, 1'b1, 32'h00002211};
    rv[4] = {32'h101, 2'b11, 1'b0, 32'h5A843322};
    for (int i = 0; i < 5; i++) issue_read(0, rv[i].addr, rv[i].size, rv[i].sext, rv[i].exp);

    // Both ports requesting continuously: last grant was port 0, so 1,0,1,0
    set_port(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    set_port(1, 1'b0, 2'b00, 1'b0, 32'h200, 32'd0);
    req_in = 2'b11;
    exp_port = 2'b10;
    for (int t = 0; t < 4; t++) begin
      got = 2'b00;
      for (int c = 0; c < 30 && got == 2'b00; c++) begin
        tick();
        got = accepted_out;
      end
      check("rr_grant", {30'd0, got}, {30'd0, exp_port});
      exp_done_q.push_back({exp_port, 1'b1, (exp_port == 2'b01) ? 32'h84332211 : 32'h00000080});
      exp_port = ~exp_port;
      if (t == 3) req_in = 2'b00;
    end
    wait_done("rr_last_done");

    // IO half write with buffer full for 3 cycles
    set_port(0, 1'b1, 2'b01, 1'b0, 32'h30000, 32'h0000BEEF);
    io_buffer_full = 1'b1;
    req_in = 2'b01;
    exp_wr_q.push_back({32'h30000, 8'hEF});
    exp_wr_q.push_back({32'h30001, 8'hBE});
    exp_done_q.push_back({2'b01, 1'b0, 32'd0});
    tick();
    check("io_accept", {30'd0, accepted_out}, 32'd1);
    req_in = 2'b00;
    check("io_blocked1", {31'd0, mem_wr}, 32'd0);
    tick();
    check("io_blocked2", {31'd0, mem_wr}, 32'd0);
    tick();
    check("io_blocked3", {31'd0, mem_wr}, 32'd0);
    io_buffer_full = 1'b0;
    tick();
    check("io_byte0", {23'd0, mem_wr, mem_dout}, {23'd0, 1'b1, 8'hEF});
    tick();
    check("io_gap", {31'd0, mem_wr}, 32'd0);
    tick();
    check("io_byte1", {23'd0, mem_wr, mem_dout}, {23'd0, 1'b1, 8'hBE});
    tick();
    check("io_done", {30'd0, done_out}, 32'd1);
    tick();

    // Flush aborts a word read at cycle 3
    set_port(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    req_in = 2'b01;
    tick();
    req_in = 2'b00;
    tick();
    tick();
    flush_pipline = 1'b1;
    tick();
    flush_pipline = 1'b0;
    check("flush_no_done", {30'd0, done_out}, 32'd0);
    check("flush_no_wr", {31'd0, mem_wr}, 32'd0);
    set_port(1, 1'b0, 2'b00, 1'b1, 32'h200, 32'd0);
    req_in = 2'b10;
    tick();
    check("flush_idle", {30'd0, accepted_out}, 32'd2);
    req_in = 2'b00;
    exp_done_q.push_back({2'b10, 1'b1, 32'hFFFFFF80});
    wait_done("after_flush_done");

    // Flush drops a new request, then cannot tear a word write
    set_port(0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hA1B2C3D4);
    req_in = 2'b01;
    flush_pipline = 1'b1;
    tick();
    check("flush_drop", {30'd0, accepted_out}, 32'd0);
    flush_pipline = 1'b0;
    exp_wr_q.push_back({32'h400, 8'hD4});
    exp_wr_q.push_back({32'h401, 8'hC3});
    exp_wr_q.push_back({32'h402, 8'hB2});
    exp_wr_q.push_back({32'h403, 8'hA1});
    exp_done_q.push_back({2'b01, 1'b0, 32'd0});
    tick();
    check("wr_accept", {30'd0, accepted_out}, 32'd1);
    req_in = 2'b00;
    tick();
    tick();
    flush_pipline = 1'b1;
    tick();
    flush_pipline = 1'b0;
    tick();
    check("wr_flush_done", {30'd0, done_out}, 32'd1);
    tick();

    // rdy_in freeze mid-write: each byte exactly once
    set_port(0, 1'b1, 2'b10, 1'b0, 32'h500, 32'h01020304);
    exp_wr_q.push_back({32'h500, 8'h04});
    exp_wr_q.push_back({32'h501, 8'h03});
    exp_wr_q.push_back({32'h502, 8'h02});
    exp_wr_q.push_back({32'h503, 8'h01});
    exp_done_q.push_back({2'b01, 1'b0, 32'd0});
    req_in = 2'b01;
    tick();
    req_in = 2'b00;
    tick();
    rdy_in = 1'b0;
    #1;
    check("freeze_wr_mask", {31'd0, mem_wr}, 32'd0);
    tick();
    check("freeze_hold", {31'd0, mem_wr}, 32'd0);
    tick();
    rdy_in = 1'b1;
    wait_done("freeze_write_done");
    issue_read(0, 32'h500, 2'b10, 1'b0, 32'h01020304);

    // Reset mid-read
    set_port(0, 1'b0, 2'b10, 1'b0, 32'h500, 32'd0);
    req_in = 2'b01;
    tick();
    req_in = 2'b00;
    tick();
    tick();
    rst_in = 1'b0;
    tick();
    check("mid_rst_mem_a", mem_a, 32'd0);
    check("mid_rst_dout_wr", {23'd0, mem_wr, mem_dout}, 32'd0);
    check("mid_rst_pulses", {28'd0, accepted_out, done_out}, 32'd0);
    check("mid_rst_rdata", rdata_out, 32'd0);
    rst_in = 1'b1;
    for (int c = 0; c < 8; c++) tick();

    // After reset port 0 has priority
    set_port(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    set_port(1, 1'b0, 2'b00, 1'b0, 32'h200, 32'd0);
    req_in = 2'b11;
    tick();
    check("post_rst_prio", {30'd0, accepted_out}, 32'd1);
    req_in = 2'b00;
    exp_done_q.push_back({2'b01, 1'b1, 32'h84332211});
    wait_done("post_rst_done");
    for (int c = 0; c < 4; c++) tick();
    check("sb_drain", exp_done_q.size() + exp_wr_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
